// File: rtl/term_pkg.sv
// Shared types and constants for the terminal writer: FSM states, control codes,
// default geometry and the printable-byte classifier.
package term_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    CLR_LINE   = 2'd2,
    CLR_SCREEN = 2'd3
  } state_t;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  localparam int         DEF_COLS      = 60;
  localparam int         DEF_ROWS      = 17;
  localparam logic [7:0] DEF_FILL_CHAR = 8'h20;

  // Everything from space upward except DEL lands in VRAM as a glyph.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

endpackage

// File: rtl/term_sweep.sv
// VRAM address register shared by clear sweeps (one 64-cell row or all 2048 cells)
// and the idle/write path, which loads the cursor cell whenever no sweep runs.
module term_sweep (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        start,
  input  logic        line_sel,
  input  logic [4:0]  row,
  input  logic [10:0] load_addr,
  output logic [10:0] addr,
  output logic        ce,
  output logic        done
);

  logic [10:0] addr_r;
  logic        active_r;
  logic        line_r;

  assign done = active_r && (addr_r[5:0] == 6'h3F) && (line_r || (addr_r[10:6] == 5'h1F));
  assign addr = addr_r;
  assign ce   = active_r;

  // Sweep counter; outside a sweep it follows the requested cursor address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_r   <= 11'd0;
      active_r <= 1'b0;
      line_r   <= 1'b0;
    end else if (start) begin
      addr_r   <= line_sel ? {row, 6'd0} : 11'd0;
      active_r <= 1'b1;
      line_r   <= line_sel;
    end else if (done) begin
      addr_r   <= load_addr;
      active_r <= 1'b0;
    end else if (active_r) begin
      addr_r   <= addr_r + 11'd1;
    end else begin
      addr_r   <= load_addr;
    end
  end

endmodule

// File: rtl/term_writer.sv
// Byte-stream terminal front end: decodes printables/control codes into VRAM writes
// and clear sweeps, owns the cursor. Define TERM_TAB_EN to honour 0x09 as a tab stop.
module term_writer
  import term_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_data,
  output logic        o_vram_ce,
  output logic        o_busy
);

  state_t      state_r, state_nxt_s;
  logic [5:0]  x_r, x_nxt_s;
  logic [4:0]  y_r, y_nxt_s, y_inc_s;
  logic [7:0]  byte_r, byte_nxt_s, data_r;
  logic        ready_r, wr_ce_r, busy_r, wr_nxt_s;
  logic        sweep_start_s, sweep_line_s, sweep_done_s, sweep_ce_s;
  logic [10:0] sweep_addr_s;
  logic [6:0]  tab_s;

  // Row below the cursor; wraps to the top instead of scrolling.
  always_comb begin
    if (y_r == 5'(ROWS - 1)) begin
      y_inc_s = 5'd0;
    end else begin
      y_inc_s = y_r + 5'd1;
    end
  end

  assign tab_s = {1'b0, x_r[5:3], 3'b000} + 7'd8;

  // Next-state, cursor and sweep-start decode.
  always_comb begin
    state_nxt_s   = state_r;
    x_nxt_s       = x_r;
    y_nxt_s       = y_r;
    byte_nxt_s    = byte_r;
    sweep_start_s = 1'b0;
    sweep_line_s  = 1'b1;
    case (state_r)
      IDLE: begin
        if (i_rx_valid && ready_r) begin
          byte_nxt_s = i_rx_data;
          if (i_rx_data == CC_FF) begin
            state_nxt_s   = CLR_SCREEN;
            sweep_start_s = 1'b1;
            sweep_line_s  = 1'b0;
          end else if (i_rx_data == CC_LF) begin
            y_nxt_s       = y_inc_s;
            state_nxt_s   = CLR_LINE;
            sweep_start_s = 1'b1;
          end else begin
            state_nxt_s = WRITE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        state_nxt_s = IDLE;
        case (byte_r)
          CC_CR: x_nxt_s = 6'd0;
          CC_BS: begin
            if (x_r != 6'd0) begin
              x_nxt_s = x_r - 6'd1;
            end else begin
              x_nxt_s = x_r;
            end
          end
`ifdef TERM_TAB_EN
          CC_TAB: begin
            if (tab_s >= 7'(COLS)) begin
              x_nxt_s       = 6'd0;
              y_nxt_s       = y_inc_s;
              state_nxt_s   = CLR_LINE;
              sweep_start_s = 1'b1;
            end else begin
              x_nxt_s = tab_s[5:0];
            end
          end
`endif
          default: begin
            if (is_printable(byte_r) && (x_r == 6'(COLS - 1))) begin
              x_nxt_s       = 6'd0;
              y_nxt_s       = y_inc_s;
              state_nxt_s   = CLR_LINE;
              sweep_start_s = 1'b1;
            end else if (is_printable(byte_r)) begin
              x_nxt_s = x_r + 6'd1;
            end else begin
              x_nxt_s = x_r;
            end
          end
        endcase
      end
      CLR_LINE: begin
        if (sweep_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CLR_LINE;
        end
      end
      CLR_SCREEN: begin
        if (sweep_done_s) begin
          state_nxt_s = IDLE;
          x_nxt_s     = 6'd0;
          y_nxt_s     = 5'd0;
        end else begin
          state_nxt_s = CLR_SCREEN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
    wr_nxt_s = (state_nxt_s == WRITE) && is_printable(byte_nxt_s);
  end

  // State, cursor and registered handshake/write outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      x_r     <= 6'd0;
      y_r     <= 5'd0;
      byte_r  <= 8'd0;
      ready_r <= 1'b0;
      wr_ce_r <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= FILL_CHAR;
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      byte_r  <= byte_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      wr_ce_r <= wr_nxt_s;
      busy_r  <= (state_nxt_s == CLR_LINE) || (state_nxt_s == CLR_SCREEN);
      data_r  <= wr_nxt_s ? byte_nxt_s : FILL_CHAR;
    end
  end

  term_sweep u_sweep (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .start     (sweep_start_s),
    .line_sel  (sweep_line_s),
    .row       (y_nxt_s),
    .load_addr ({y_nxt_s, x_nxt_s}),
    .addr      (sweep_addr_s),
    .ce        (sweep_ce_s),
    .done      (sweep_done_s)
  );

  assign o_rx_ready  = ready_r;
  assign o_vram_addr = sweep_addr_s;
  assign o_vram_data = data_r;
  assign o_vram_ce   = wr_ce_r | sweep_ce_s;
  assign o_busy      = busy_r;

endmodule

// File: tb/tb_term_writer.sv
// Directed bench for term_writer: writes, auto-wrap, LF wrap, FF sweep, BS/CR, reset abort, TAB.
module tb_term_writer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_data;
  logic        o_vram_ce;
  logic        o_busy;

  int tests_run = 0;
  int tests_failed = 0;

  term_writer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_vram_addr (o_vram_addr),
    .o_vram_data (o_vram_data),
    .o_vram_ce   (o_vram_ce),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    step();
    step();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
  endtask

  // Waits (bounded) for ready, presents b for one accepting edge; returns 1 ns after that edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (o_rx_ready !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= 5000) begin
      tests_failed++;
      $display("FAIL ready_timeout: ready=%b required 1 before byte %h", o_rx_ready, b);
    end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    step();
    i_rx_valid = 1'b0;
  endtask

  // Checks a sweep of len cycles starting at base, starting in the current cycle.
  task automatic check_sweep(input string name, input logic [10:0] base, input int len);
    int bad = 0;
    for (int k = 0; k < len; k++) begin
      if (o_vram_ce !== 1'b1 || o_vram_addr !== base + 11'(k) || o_vram_data !== 8'h20 ||
          o_busy !== 1'b1 || o_rx_ready !== 1'b0) begin
        if (bad == 0)
          $display("sweep %s first bad cycle %0d: ce=%b addr=%h data=%h busy=%b ready=%b",
                   name, k, o_vram_ce, o_vram_addr, o_vram_data, o_busy, o_rx_ready);
        bad++;
      end
      step();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d bad sweep cycles, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    step();
    step();
    tests_run++;
    if ({o_vram_ce, o_busy, o_rx_ready, o_vram_addr, o_vram_data} !== {3'b000, 11'h000, 8'h20}) begin
      tests_failed++;
      $display("FAIL reset_values: ce=%b busy=%b ready=%b addr=%h data=%h required 0 0 0 000 20",
               o_vram_ce, o_busy, o_rx_ready, o_vram_addr, o_vram_data);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    tests_run++;
    if (o_rx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: ready=%b required 1", o_rx_ready);
    end
  endtask

  task automatic test_write();
    send(8'h41);
    tests_run++;
    if ({o_vram_ce, o_vram_addr, o_vram_data, o_rx_ready} !== {1'b1, 11'h000, 8'h41, 1'b0}) begin
      tests_failed++;
      $display("FAIL write_A: ce=%b addr=%h data=%h ready=%b required 1 000 41 0",
               o_vram_ce, o_vram_addr, o_vram_data, o_rx_ready);
    end
    step();
    tests_run++;
    if ({o_vram_ce, o_vram_addr, o_rx_ready} !== {1'b0, 11'h001, 1'b1}) begin
      tests_failed++;
      $display("FAIL write_A_after: ce=%b addr=%h ready=%b required 0 001 1",
               o_vram_ce, o_vram_addr, o_rx_ready);
    end
  endtask

  task automatic test_autowrap();
    do_reset();
    for (int i = 0; i < 60; i++) send(8'h30 + 8'(i % 10));
    tests_run++;
    if ({o_vram_ce, o_vram_addr, o_vram_data} !== {1'b1, 11'h03B, 8'h39}) begin
      tests_failed++;
      $display("FAIL wrap_last_write: ce=%b addr=%h data=%h required 1 03b 39",
               o_vram_ce, o_vram_addr, o_vram_data);
    end
    step();
    check_sweep("wrap_clr_line", 11'h040, 64);
    tests_run++;
    if ({o_vram_ce, o_busy, o_rx_ready, o_vram_addr} !== {3'b001, 11'h040}) begin
      tests_failed++;
      $display("FAIL wrap_idle: ce=%b busy=%b ready=%b addr=%h required 0 0 1 040",
               o_vram_ce, o_busy, o_rx_ready, o_vram_addr);
    end
  endtask

  task automatic test_lf_wrap();
    // cursor at (0,1); fifteen LFs bring it to row 16, then five chars to x=5
    for (int i = 0; i < 15; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    step();
    tests_run++;
    if (o_vram_addr !== 11'h405) begin
      tests_failed++;
      $display("FAIL lf_setup: addr=%h required 405", o_vram_addr);
    end
    send(8'h0A);
    check_sweep("lf_wrap_clr", 11'h000, 64);
    tests_run++;
    if ({o_vram_ce, o_rx_ready, o_vram_addr} !== {2'b01, 11'h005}) begin
      tests_failed++;
      $display("FAIL lf_wrap_idle: ce=%b ready=%b addr=%h required 0 1 005",
               o_vram_ce, o_rx_ready, o_vram_addr);
    end
  endtask

  task automatic test_ff();
    send(8'h0C);
    check_sweep("ff_sweep", 11'h000, 2048);
    tests_run++;
    if ({o_vram_ce, o_busy, o_rx_ready, o_vram_addr} !== {3'b001, 11'h000}) begin
      tests_failed++;
      $display("FAIL ff_idle: ce=%b busy=%b ready=%b addr=%h required 0 0 1 000",
               o_vram_ce, o_busy, o_rx_ready, o_vram_addr);
    end
  endtask

  task automatic test_bs_cr();
    int ce_seen = 0;
    for (int i = 0; i < 3; i++) send(8'h0A);
    send(8'h08);
    step();
    tests_run++;
    if (o_vram_addr !== 11'h0C0) begin
      tests_failed++;
      $display("FAIL bs_at_x0: addr=%h required 0c0", o_vram_addr);
    end
    send(8'h78);
    send(8'h08);
    step();
    tests_run++;
    if (o_vram_addr !== 11'h0C0) begin
      tests_failed++;
      $display("FAIL bs_after_x: addr=%h required 0c0", o_vram_addr);
    end
    for (int i = 0; i < 7; i++) send(8'h62);
    step();
    tests_run++;
    if (o_vram_addr !== 11'h0C7) begin
      tests_failed++;
      $display("FAIL cr_setup: addr=%h required 0c7", o_vram_addr);
    end
    send(8'h0D);
    ce_seen += int'(o_vram_ce);
    step();
    tests_run++;
    if ({o_vram_addr, o_rx_ready} !== {11'h0C0, 1'b1}) begin
      tests_failed++;
      $display("FAIL cr: addr=%h ready=%b required 0c0 1", o_vram_addr, o_rx_ready);
    end
    send(8'h07);
    ce_seen += int'(o_vram_ce);
    step();
    ce_seen += int'(o_vram_ce);
    tests_run++;
    if (ce_seen != 0 || o_vram_addr !== 11'h0C0) begin
      tests_failed++;
      $display("FAIL ignored_bel: ce cycles=%0d addr=%h required 0 0c0", ce_seen, o_vram_addr);
    end
  endtask

  task automatic test_tab();
    int ce_seen;
    do_reset();
    for (int i = 0; i < 3; i++) send(8'h63);
    send(8'h09);
    ce_seen = int'(o_vram_ce);
    step();
`ifdef TERM_TAB_EN
    tests_run++;
    if (ce_seen != 0 || o_vram_addr !== 11'h008) begin
      tests_failed++;
      $display("FAIL tab_3_to_8: ce=%0d addr=%h required 0 008", ce_seen, o_vram_addr);
    end
    for (int i = 0; i < 49; i++) send(8'h64);
    step();
    tests_run++;
    if (o_vram_addr !== 11'h039) begin
      tests_failed++;
      $display("FAIL tab_setup57: addr=%h required 039", o_vram_addr);
    end
    send(8'h09);
    step();
    check_sweep("tab_wrap_clr", 11'h040, 64);
    tests_run++;
    if ({o_rx_ready, o_vram_addr} !== {1'b1, 11'h040}) begin
      tests_failed++;
      $display("FAIL tab_wrap_idle: ready=%b addr=%h required 1 040", o_rx_ready, o_vram_addr);
    end
`else
    tests_run++;
    if (ce_seen != 0 || o_vram_addr !== 11'h003 || o_rx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL tab_ignored: ce=%0d addr=%h ready=%b required 0 003 1",
               ce_seen, o_vram_addr, o_rx_ready);
    end
`endif
  endtask

  task automatic test_reset_mid_sweep();
    send(8'h41);
    send(8'h0C);
    for (int i = 0; i < 100; i++) step();
    tests_run++;
    if ({o_vram_ce, o_vram_addr} !== {1'b1, 11'd100}) begin
      tests_failed++;
      $display("FAIL sweep_cycle100: ce=%b addr=%h required 1 064", o_vram_ce, o_vram_addr);
    end
    #1;
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_vram_ce, o_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_abort_ce: ce=%b busy=%b required 0 0", o_vram_ce, o_busy);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    tests_run++;
    if ({o_vram_ce, o_rx_ready, o_vram_addr} !== {2'b01, 11'h000}) begin
      tests_failed++;
      $display("FAIL reset_release: ce=%b ready=%b addr=%h required 0 1 000",
               o_vram_ce, o_rx_ready, o_vram_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_autowrap();
    test_lf_wrap();
    test_ff();
    test_bs_cr();
    test_tab();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/term_writer.md
Name: term_writer

Overview:
- Upstream stage of the text engine. It consumes received serial bytes through a valid/ready handshake.
- It interprets printable characters and control codes, and drives the VRAM write port (address, data, chip enable) of the text engine.
- It owns the terminal cursor position. When idle, the VRAM address output equals the cursor cell, so the text engine draws its cursor there.

Parameters:
- COLS, 60, visible columns; cursor x wraps at COLS-1 (max 64).
- ROWS, 17, visible rows; cursor y wraps at ROWS-1 (max 32).
- FILL_CHAR, 8'h20, code written by clear operations.

Ports:
- i_clk  in  1  system clock (24 MHz), same clock as the VRAM A port.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  i_rx_data valid.
- o_rx_ready  out  1  block can accept a byte this cycle.
- o_vram_addr  out  11  VRAM write address {5'y, 6'x}; equals the cursor cell when idle.
- o_vram_data  out  8  VRAM write data.
- o_vram_ce  out  1  VRAM write enable, one cycle per cell.
- o_busy  out  1  high during clear sweeps.

Behaviour:
- Clock and reset (already decided): one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: cursor (x,y)=(0,0), o_vram_addr=0, o_vram_data=FILL_CHAR, o_vram_ce=0, o_busy=0, state IDLE.
- Outputs: all registered. o_rx_ready=1 only in IDLE and not in reset.
- Handshake: a byte is accepted on a rising edge where i_rx_valid & o_rx_ready. The byte is latched, and o_rx_ready drops the next cycle.
- States:
  - IDLE: wait for a byte; decode it on acceptance.
  - WRITE:
    - Lasts one cycle: o_vram_ce=1, addr={y,x}, data=byte.
    - Next cycle: cursor advances, state returns to IDLE.
    - Throughput: one printable byte per 2 cycles (accept at N, ce at N+1, ready again at N+2).
  - CLR_LINE:
    - Sweeps cell x=0..63 of the row at cursor y, writing FILL_CHAR with ce=1 for 64 consecutive cycles.
    - Then returns to IDLE with addr restored to the cursor cell.
  - CLR_SCREEN:
    - Sweeps addr 0..2047, writing FILL_CHAR for 2048 consecutive cycles.
    - Then cursor=(0,0) and IDLE.
- Decode:
  - 0x20-0x7E and 0x80-0xFF: printable, go to WRITE. After the write, x+1.
    - If x was COLS-1, then x=0 and a newline is performed.
  - 0x0D (CR): x=0; no write; back to IDLE after 1 cycle.
  - 0x0A (LF): newline.
    - y+1; if y was ROWS-1, y=0 (wrap to top, no scroll).
    - x unchanged.
    - Then CLR_LINE on the new row.
  - 0x08 (BS): if x>0 then x-1; no write. At x=0 nothing happens.
  - 0x0C (FF): CLR_SCREEN.
  - Other codes below 0x20 (and 0x7F): ignored; 1 cycle, then IDLE.
- Auto-wrap from a printable at column COLS-1 is a newline, so it also clears the new row.
- o_busy=1 for the whole of CLR_LINE/CLR_SCREEN. During a sweep o_vram_addr follows the sweep, not the cursor.
- During a sweep, i_rx_valid is held off (ready=0); no byte is lost or reordered.
- Reset asserted mid-sweep or mid-write:
  - ce=0 immediately (asynchronous); sweep aborted.
  - Cursor home; the pending byte is discarded.
  - VRAM contents are left partially cleared.

Optional Feature:
- TERM_TAB_EN defined: 0x09 (TAB) sets x to the next multiple of 8. No write; 1 cycle.
  - If the result is ≥ COLS: x=0 plus newline (with CLR_LINE).
- TERM_TAB_EN undefined: 0x09 is ignored like the other control codes.

Decomposition:
- Package term_pkg holds:
  - the state enum (IDLE, WRITE, CLR_LINE, CLR_SCREEN);
  - control-code constants (CC_BS, CC_TAB, CC_LF, CC_FF, CC_CR);
  - default COLS, ROWS and FILL_CHAR.
- One sub-module, term_sweep: an 11-bit address counter with start, length-select (line/screen), row base, ce output and done pulse. It is used by both clear states.

Test Plan:
- Reset, then send 'A' (0x41) at cycle 0 → ce=1 at cycle 1 with addr=0x000, data=0x41; addr=0x001 and ready=1 at cycle 2.
- Send 60 printables from (0,0) → the last write is at addr 0x03B. Then 64 cycles of ce with FILL_CHAR at 0x040-0x07F; idle addr=0x040.
- Cursor at (5,16), send LF → y wraps to 0: 64 clears at 0x000-0x03F; idle addr=0x005.
- Send FF → o_busy=1 and ce=1 for exactly 2048 cycles over 0x000-0x7FF; ready=0 throughout; then addr=0x000 and ready=1.
- At (0,3): BS → addr stays 0x0C0. Send 'x', then BS → addr 0x0C0. CR from (7,3) → addr 0x0C0. Byte 0x07 → no ce.
- Assert i_rst_n=0 at sweep cycle 100 of an FF → ce drops the same cycle; after release, addr=0 and ready=1. With TERM_TAB_EN defined, TAB from x=3 → x=8; from x=57 → newline and clear.
